csr_reg_block: RTL and testbench
================================

// Module: csr_reg_block
// PURPOSE
//  Register file that consumes the generic CPU register bus issued by apb4_slave (req/is_wr/addr/wr_data/biten).
//  Executes each request against 7 CSRs and returns ready/rd_data/err. Exports control fields and an interrupt.
//  Sits directly downstream of the APB bridge and upstream of the IP's datapath.
// PARAMETERS
//  ADDR_WIDTH  5             byte address width; word index = bus_addr[ADDR_WIDTH-1:2]
//  DATA_WIDTH  32            register/bus data width; multiple of 8
//  CTRL_RESET  32'h0         reset value of CTRL
//  ID_VALUE    32'hC5A0_0001 constant returned by ID
// PORTS
//  clk               in   1             single clock, rising edge
//  rst_n             in   1             asynchronous reset, active-low
//  bus_req           in   1             request; held high by upstream until bus_ready
//  bus_req_is_wr     in   1             1=write, 0=read
//  bus_addr          in   ADDR_WIDTH    byte address
//  bus_wr_data       in   DATA_WIDTH    write data
//  bus_wr_biten      in   DATA_WIDTH/8  byte-lane write enables
//  bus_ready         out  1             one-cycle completion pulse
//  bus_rd_data       out  DATA_WIDTH    read data, valid with bus_ready, else 0
//  bus_err           out  1             error, valid with bus_ready, else 0
//  bus_req_stall_wr  out  1             1 while FSM not IDLE
//  bus_req_stall_rd  out  1             1 while FSM not IDLE
//  hw_status         in   DATA_WIDTH    live value for STATUS
//  hw_event          in   DATA_WIDTH    per-bit single-cycle event pulses into INT_STATUS
//  ctrl_q, cfg_q     out  DATA_WIDTH    current CTRL / CFG contents
//  irq               out  1             registered |(INT_STATUS & INT_ENABLE)
// BEHAVIOUR
//  Map: 0x00 CTRL RW | 0x04 CFG RW | 0x08 STATUS RO | 0x0C INT_STATUS W1C | 0x10 INT_ENABLE RW
//       0x14 SCRATCH RW | 0x18 ID RO | 0x1C unmapped.
//  Reset: bus_ready=0, bus_rd_data=0, bus_err=0, stalls=0, irq=0; CTRL=CTRL_RESET; all other storage 0.
//  FSM IDLE -> RESP -> IDLE. bus_req is sampled only in IDLE.
//  Request seen in IDLE at cycle N: write commits at end of N; bus_ready, rd_data and err are registered and high in N+1.
//  RESP always returns to IDLE. bus_req still high in the IDLE cycle is a new request; the upstream bridge drops it after ready.
//  Writes: only lanes with biten=1 change. biten=0 is a legal no-op with err=0.
//  INT_STATUS write: 1 clears that bit, 0 leaves it unchanged.
//  Error (err=1, no state change, rd_data=0): bus_addr[1:0]!=0, unmapped offset, or write to STATUS or ID.
//  INT_STATUS: bit set on hw_event=1; set wins over same-cycle W1C clear; a read does not clear.
//  STATUS read returns hw_status sampled in cycle N.
//  irq is updated one cycle after INT_STATUS/INT_ENABLE change.
//  Reset asserted mid-transaction: FSM to IDLE immediately, pending response discarded, no ready pulse.
// CONFIGURATION
//  CSR_RD_PIPE_EN defined: FSM IDLE -> WAIT -> RESP.
//   - Read data is captured into a pipeline flop in WAIT; bus_ready is in N+2 for all accesses.
//   - Writes still commit at end of N.
//  Not defined: WAIT state absent, latency N+1.
// STRUCTURE
//  Package csr_reg_pkg: register offset localparams, csr_state_e enum (IDLE/WAIT/RESP), ID default.
//  Sub-module csr_field_reg: DATA_WIDTH byte-enabled RW register with reset value.
//   - Instantiated for CTRL, CFG, INT_ENABLE, SCRATCH.
//   - Decode, W1C, FSM and response muxing stay in csr_reg_block.
// TESTING
//  1 Reset release, read all 7 offsets -> CTRL=CTRL_RESET, ID=32'hC5A0_0001, others 0, err=0.
//  2 Write SCRATCH 0xDEADBEEF biten=4'b0101, then read -> 0x00AD00EF.
//    Ready exactly 1 cycle after req (2 with CSR_RD_PIPE_EN).
//  3 hw_event=0x5, INT_ENABLE=0x4 -> irq=1 next cycle; write INT_STATUS=0x4 -> INT_STATUS=0x1, irq=0.
//  4 hw_event bit0 pulse in the same cycle as a W1C of bit0 -> INT_STATUS[0] stays 1.
//  5 Read 0x1C, read 0x02, write 0x18 -> each err=1, rd_data=0; ID unchanged.
//  6 Assert rst_n low the cycle after req on a CFG write -> no bus_ready; CFG=0 after reset.
//    Back-to-back APB writes -> each committed exactly once.

Source files
------------

// File: rtl/csr_reg_pkg.sv
// rtl/csr_reg_pkg.sv - register map, FSM state type and ID default for csr_reg_block
package csr_reg_pkg;

    // Word indices; the byte offset of each register is index * 4.
    localparam int unsigned REG_CTRL       = 0;
    localparam int unsigned REG_CFG        = 1;
    localparam int unsigned REG_STATUS     = 2;
    localparam int unsigned REG_INT_STATUS = 3;
    localparam int unsigned REG_INT_ENABLE = 4;
    localparam int unsigned REG_SCRATCH    = 5;
    localparam int unsigned REG_ID         = 6;
    localparam int unsigned NUM_REGS       = 7;

    localparam logic [31:0] ID_DEFAULT = 32'hC5A0_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } csr_state_e;

endpackage

// File: rtl/csr_field_reg.sv
// rtl/csr_field_reg.sv - byte-enabled read/write register with reset value
module csr_field_reg
    import csr_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_biten,
    output logic [DATA_WIDTH-1:0]   q
);

    localparam int NB = DATA_WIDTH / 8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_biten[i]) begin
                    q[i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/csr_reg_block.sv
// rtl/csr_reg_block.sv - 7-entry CSR file behind the CPU register bus; CSR_RD_PIPE_EN adds a read pipeline stage
module csr_reg_block
    import csr_reg_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(ID_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bus_req,
    input  logic                    bus_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    input  logic [DATA_WIDTH-1:0]   bus_wr_data,
    input  logic [DATA_WIDTH/8-1:0] bus_wr_biten,
    output logic                    bus_ready,
    output logic [DATA_WIDTH-1:0]   bus_rd_data,
    output logic                    bus_err,
    output logic                    bus_req_stall_wr,
    output logic                    bus_req_stall_rd,
    input  logic [DATA_WIDTH-1:0]   hw_status,
    input  logic [DATA_WIDTH-1:0]   hw_event,
    output logic [DATA_WIDTH-1:0]   ctrl_q,
    output logic [DATA_WIDTH-1:0]   cfg_q,
    output logic                    irq
);

    localparam int NB = DATA_WIDTH / 8;

    csr_state_e            state_q, state_d;
    logic [31:0]           word_num;
    logic                  accept, acc_err, wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] be_mask;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] int_status_q, int_enable_q, scratch_q;
    logic [DATA_WIDTH-1:0] w1c_clr;
    logic                  resp_fire, resp_err_src;
    logic [DATA_WIDTH-1:0] resp_data_src;
    logic                  ready_q, err_q, irq_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    assign word_num = 32'(bus_addr[ADDR_WIDTH-1:2]);
    assign accept   = (state_q == IDLE) && bus_req;

    // Misaligned, unmapped and read-only-target writes are rejected before any state changes.
    assign acc_err = accept && ((bus_addr[1:0] != 2'b00) ||
                                (word_num >= NUM_REGS) ||
                                (bus_req_is_wr && ((word_num == REG_STATUS) || (word_num == REG_ID))));
    assign wr_ok   = accept && bus_req_is_wr && !acc_err;
    assign rd_ok   = accept && !bus_req_is_wr && !acc_err;

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < NB; i++) begin
            be_mask[i*8 +: 8] = {8{bus_wr_biten[i]}};
        end
    end

    csr_field_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE(CTRL_RESET)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_ok && (word_num == REG_CTRL)),
        .wr_data  (bus_wr_data),
        .wr_biten (bus_wr_biten),
        .q        (ctrl_q)
    );

    csr_field_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE('0)) u_cfg (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_ok && (word_num == REG_CFG)),
        .wr_data  (bus_wr_data),
        .wr_biten (bus_wr_biten),
        .q        (cfg_q)
    );

    csr_field_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE('0)) u_int_enable (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_ok && (word_num == REG_INT_ENABLE)),
        .wr_data  (bus_wr_data),
        .wr_biten (bus_wr_biten),
        .q        (int_enable_q)
    );

    csr_field_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE('0)) u_scratch (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_ok && (word_num == REG_SCRATCH)),
        .wr_data  (bus_wr_data),
        .wr_biten (bus_wr_biten),
        .q        (scratch_q)
    );

    assign w1c_clr = (wr_ok && (word_num == REG_INT_STATUS)) ? (bus_wr_data & be_mask) : '0;

    // OR-ing the event in after the clear lets a same-cycle event win over W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_status_q <= '0;
        end else begin
            int_status_q <= (int_status_q & ~w1c_clr) | hw_event;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (rd_ok) begin
            case (word_num)
                REG_CTRL:       rd_mux = ctrl_q;
                REG_CFG:        rd_mux = cfg_q;
                REG_STATUS:     rd_mux = hw_status;
                REG_INT_STATUS: rd_mux = int_status_q;
                REG_INT_ENABLE: rd_mux = int_enable_q;
                REG_SCRATCH:    rd_mux = scratch_q;
                REG_ID:         rd_mux = ID_VALUE;
                default:        rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus_req) begin
`ifdef CSR_RD_PIPE_EN
                    state_d = WAIT;
`else
                    state_d = RESP;
`endif
                end
            end
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef CSR_RD_PIPE_EN
    logic [DATA_WIDTH-1:0] pipe_data_q;
    logic                  pipe_err_q;

    // Holds the cycle-N response through WAIT so the output flops load it one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_data_q <= '0;
            pipe_err_q  <= 1'b0;
        end else if (accept) begin
            pipe_data_q <= rd_mux;
            pipe_err_q  <= acc_err;
        end
    end

    assign resp_fire     = (state_q == WAIT);
    assign resp_data_src = pipe_data_q;
    assign resp_err_src  = pipe_err_q;
`else
    assign resp_fire     = accept;
    assign resp_data_src = rd_mux;
    assign resp_err_src  = acc_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ready_q   <= resp_fire;
            rd_data_q <= resp_fire ? resp_data_src : '0;
            err_q     <= resp_fire && resp_err_src;
            irq_q     <= |(int_status_q & int_enable_q);
        end
    end

    assign bus_ready        = ready_q;
    assign bus_rd_data      = rd_data_q;
    assign bus_err          = err_q;
    assign bus_req_stall_wr = (state_q != IDLE);
    assign bus_req_stall_rd = (state_q != IDLE);
    assign irq              = irq_q;

endmodule

// File: tb/tb_csr_reg_block.sv
// tb/tb_csr_reg_block.sv - randomized bench for csr_reg_block with cycle-level reference model
module tb_csr_reg_block;

`ifdef CSR_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_req_is_wr = 1'b0;
    logic [4:0]  bus_addr = '0;
    logic [31:0] bus_wr_data = '0;
    logic [3:0]  bus_wr_biten = '0;
    logic        bus_ready;
    logic [31:0] bus_rd_data;
    logic        bus_err;
    logic        bus_req_stall_wr;
    logic        bus_req_stall_rd;
    logic [31:0] hw_status = '0;
    logic [31:0] hw_event = '0;
    logic [31:0] ctrl_q;
    logic [31:0] cfg_q;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit rand_mode = 1'b0;

    csr_reg_block dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus_req          (bus_req),
        .bus_req_is_wr    (bus_req_is_wr),
        .bus_addr         (bus_addr),
        .bus_wr_data      (bus_wr_data),
        .bus_wr_biten     (bus_wr_biten),
        .bus_ready        (bus_ready),
        .bus_rd_data      (bus_rd_data),
        .bus_err          (bus_err),
        .bus_req_stall_wr (bus_req_stall_wr),
        .bus_req_stall_rd (bus_req_stall_rd),
        .hw_status        (hw_status),
        .hw_event         (hw_event),
        .ctrl_q           (ctrl_q),
        .cfg_q            (cfg_q),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Reference model: register contents as plain arrays, responses as a due-cycle queue.
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] m_rw[0:5];
    logic [31:0] m_ist = '0;
    int          cyc = 0;
    int          busy_left = 0;
    logic        e_ready = 0, e_err = 0, e_stall = 0, e_irq = 0;
    logic [31:0] e_rd = '0, e_ctrl = '0, e_cfg = '0;

    initial begin
        for (int i = 0; i < 6; i++) m_rw[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 6; i++) m_rw[i] = '0;
                m_ist = '0;
                rq.delete();
                busy_left = 0;
                e_ready = 0; e_err = 0; e_stall = 0; e_irq = 0;
                e_rd = '0; e_ctrl = '0; e_cfg = '0;
            end else begin
                logic        can, er;
                logic [31:0] clr, rd, msk;
                int          idx;
                resp_t       r;
                cyc++;
                can = (busy_left == 0);
                if (busy_left > 0) busy_left--;
                e_irq = |(m_ist & m_rw[4]);
                clr = '0;
                if (can && bus_req) begin
                    idx = int'(bus_addr) / 4;
                    er = (bus_addr[1:0] != 2'b00) || (idx >= 7) ||
                         (bus_req_is_wr && (idx == 2 || idx == 6));
                    rd = '0;
                    msk = '0;
                    for (int b = 0; b < 4; b++) if (bus_wr_biten[b]) msk = msk | (32'hFF << (8 * b));
                    if (!er && !bus_req_is_wr) begin
                        if (idx == 2)      rd = hw_status;
                        else if (idx == 3) rd = m_ist;
                        else if (idx == 6) rd = 32'hC5A0_0001;
                        else               rd = m_rw[idx];
                    end
                    if (!er && bus_req_is_wr) begin
                        if (idx == 3) clr = bus_wr_data & msk;
                        else          m_rw[idx] = (m_rw[idx] & ~msk) | (bus_wr_data & msk);
                    end
                    r.due = cyc + LAT - 1;
                    r.data = rd;
                    r.err = er;
                    rq.push_back(r);
                    busy_left = LAT;
                end
                m_ist = (m_ist & ~clr) | hw_event;
                e_ready = 0; e_rd = '0; e_err = 0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    r = rq.pop_front();
                    e_ready = 1; e_rd = r.data; e_err = r.err;
                end
                e_stall = (busy_left > 0);
                e_ctrl = m_rw[0];
                e_cfg = m_rw[1];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("ready", 32'(bus_ready), 32'(e_ready));
            check("rd_data", bus_rd_data, e_rd);
            check("err", 32'(bus_err), 32'(e_err));
            check("stall_wr", 32'(bus_req_stall_wr), 32'(e_stall));
            check("stall_rd", 32'(bus_req_stall_rd), 32'(e_stall));
            check("ctrl_q", ctrl_q, e_ctrl);
            check("cfg_q", cfg_q, e_cfg);
            check("irq", 32'(irq), 32'(e_irq));
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
        if (rand_mode) begin
            hw_event = $urandom & $urandom & $urandom;
            hw_status = $urandom;
        end else begin
            hw_event = '0;
        end
    endtask

    task automatic xact(input bit wr, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit last,
                        output logic [31:0] rdata, output logic err, output int lat);
        bit got;
        bus_req = 1'b1;
        bus_req_is_wr = wr;
        bus_addr = a;
        bus_wr_data = d;
        bus_wr_biten = be;
        rdata = '0;
        err = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            lat++;
            if (bus_ready) begin
                got = 1'b1;
                rdata = bus_rd_data;
                err = bus_err;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout addr=%h actual=no_ready expected=ready", a);
        end
        if (last) bus_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] rst_exp[0:6];
        rst_exp[0] = 32'h0; rst_exp[1] = 32'h0; rst_exp[2] = 32'h0; rst_exp[3] = 32'h0;
        rst_exp[4] = 32'h0; rst_exp[5] = 32'h0; rst_exp[6] = 32'hC5A0_0001;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            xact(1'b0, 5'(i * 4), '0, '0, 1'b1, rd, er, lat);
            check($sformatf("reset_read_%0d", i), rd, rst_exp[i]);
            check($sformatf("reset_err_%0d", i), 32'(er), 32'h0);
        end

        step();
        xact(1'b1, 5'h14, 32'hDEAD_BEEF, 4'b0101, 1'b1, rd, er, lat);
        check("scratch_wr_err", 32'(er), 32'h0);
        check("scratch_wr_latency", 32'(lat), 32'(LAT));
        xact(1'b0, 5'h14, '0, '0, 1'b1, rd, er, lat);
        check("scratch_rd", rd, 32'h00AD_00EF);

        hw_status = 32'h1234_5678;
        xact(1'b0, 5'h08, '0, '0, 1'b1, rd, er, lat);
        check("status_rd", rd, 32'h1234_5678);

        xact(1'b1, 5'h10, 32'h4, 4'hF, 1'b1, rd, er, lat);
        hw_event = 32'h5;
        step();
        step();
        check("irq_set", 32'(irq), 32'h1);
        xact(1'b1, 5'h0C, 32'h4, 4'hF, 1'b1, rd, er, lat);
        step();
        step();
        check("irq_clr", 32'(irq), 32'h0);
        xact(1'b0, 5'h0C, '0, '0, 1'b1, rd, er, lat);
        check("int_status_after_w1c", rd, 32'h1);

        xact(1'b1, 5'h0C, 32'h1, 4'hF, 1'b1, rd, er, lat);
        step();
        hw_event = 32'h1;
        xact(1'b1, 5'h0C, 32'h1, 4'hF, 1'b1, rd, er, lat);
        xact(1'b0, 5'h0C, '0, '0, 1'b1, rd, er, lat);
        check("event_beats_w1c", rd, 32'h1);

        xact(1'b0, 5'h1C, '0, '0, 1'b1, rd, er, lat);
        check("unmapped_err", 32'(er), 32'h1);
        check("unmapped_rd", rd, 32'h0);
        xact(1'b0, 5'h02, '0, '0, 1'b1, rd, er, lat);
        check("misaligned_err", 32'(er), 32'h1);
        check("misaligned_rd", rd, 32'h0);
        xact(1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, er, lat);
        check("id_write_err", 32'(er), 32'h1);
        xact(1'b0, 5'h18, '0, '0, 1'b1, rd, er, lat);
        check("id_unchanged", rd, 32'hC5A0_0001);

        step();
        bus_req = 1'b1;
        bus_req_is_wr = 1'b1;
        bus_addr = 5'h04;
        bus_wr_data = 32'hAAAA_5555;
        bus_wr_biten = 4'hF;
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_no_ready", 32'(bus_ready), 32'h0);
        end
        rst_n = 1'b1;
        step();
        xact(1'b0, 5'h04, '0, '0, 1'b1, rd, er, lat);
        check("cfg_after_reset", rd, 32'h0);

        xact(1'b1, 5'h00, 32'h11, 4'hF, 1'b0, rd, er, lat);
        xact(1'b1, 5'h04, 32'h22, 4'hF, 1'b0, rd, er, lat);
        xact(1'b1, 5'h14, 32'h33, 4'hF, 1'b1, rd, er, lat);
        xact(1'b0, 5'h00, '0, '0, 1'b1, rd, er, lat);
        check("b2b_ctrl", rd, 32'h11);
        xact(1'b0, 5'h04, '0, '0, 1'b1, rd, er, lat);
        check("b2b_cfg", rd, 32'h22);
        xact(1'b0, 5'h14, '0, '0, 1'b1, rd, er, lat);
        check("b2b_scratch", rd, 32'h33);

        rand_mode = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a;
            bit         last;
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            last = ($urandom_range(0, 3) != 0);
            xact(1'($urandom), a, $urandom, 4'($urandom), last, rd, er, lat);
            if (last) repeat ($urandom_range(0, 2)) step();
        end
        bus_req = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
